// File: rtl/uart_password_rx.sv
// 8N1 UART receiver feeding an in-order password comparator with sticky unlock/fail LEDs.
// Optional build macro FAIL_LOCKOUT_EN: first wrong byte or framing error locks the comparator out until reset.
module uart_password_rx #(
    parameter int                    BAUD_P   = 104,
    parameter int                    PASS_LEN = 8,
    parameter logic [8*PASS_LEN-1:0] PASSWORD = 64'h293a216b33713234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [3:0] char_idx,
    output logic       unlocked,
    output logic       led_g_n,
    output logic       led_r_n
);
    localparam logic [6:0] HALF_M1 = 7'(BAUD_P / 2 - 1);
    localparam logic [6:0] FULL_M1 = 7'(BAUD_P - 1);
    localparam logic [3:0] LEN4    = 4'(PASS_LEN);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [6:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [3:0] char_idx_q, char_idx_d;
    logic       unlocked_q, unlocked_d;
    logic       fail_q, fail_d;
    logic       cmp_en;
`ifdef FAIL_LOCKOUT_EN
    logic       lockout_q, lockout_d;
`endif

    // Password bytes padded to 16 entries so the 4-bit index always lands in range.
    logic [7:0] pw_bytes [16];
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pw
            if (gi < PASS_LEN) begin : g_used
                assign pw_bytes[gi] = PASSWORD[8*gi +: 8];
            end else begin : g_pad
                assign pw_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s_q;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        char_idx_d = char_idx_q;
        unlocked_d = unlocked_q;
        fail_d     = fail_q;
`ifdef FAIL_LOCKOUT_EN
        lockout_d  = lockout_q;
        cmp_en     = !unlocked_q && !lockout_q;
`else
        cmp_en     = !unlocked_q;
`endif
        if (cmp_en && rx_valid_q) begin
            if (rx_data_q == pw_bytes[char_idx_q]) begin
                char_idx_d = char_idx_q + 4'd1;
                if (char_idx_q + 4'd1 == LEN4) begin
                    unlocked_d = 1'b1;
                    fail_d     = 1'b0;
                end
            end else begin
                fail_d = 1'b1;
`ifdef FAIL_LOCKOUT_EN
                lockout_d  = 1'b1;
                char_idx_d = '0;
`else
                // A wrong byte may itself be the start of a fresh attempt.
                char_idx_d = (rx_data_q == pw_bytes[0]) ? 4'd1 : 4'd0;
`endif
            end
        end else if (cmp_en && frame_err_q) begin
            fail_d     = 1'b1;
            char_idx_d = '0;
`ifdef FAIL_LOCKOUT_EN
            lockout_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            char_idx_q  <= '0;
            unlocked_q  <= 1'b0;
            fail_q      <= 1'b0;
`ifdef FAIL_LOCKOUT_EN
            lockout_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            char_idx_q  <= char_idx_d;
            unlocked_q  <= unlocked_d;
            fail_q      <= fail_d;
`ifdef FAIL_LOCKOUT_EN
            lockout_q   <= lockout_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign char_idx  = char_idx_q;
    assign unlocked  = unlocked_q;
    assign led_g_n   = !unlocked_q;
`ifdef FAIL_LOCKOUT_EN
    assign led_r_n   = !(fail_q || lockout_q);
`else
    assign led_r_n   = !fail_q;
`endif
endmodule
